reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 104 ++++++++++
 tb/tb_reg_file_sb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with a per-register scoreboard: busy bits mark pending writebacks,
// with optional same-cycle write-to-read forwarding and a registered busy counter.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic [AW:0]     busy_cnt
);
    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW:0]      cnt_r;
    logic             wr_ok_s;
    logic             iss_ok_s;
    logic             inc_s;
    logic             dec_s;
    logic [XLEN:0]    rd1_s;
    logic [XLEN:0]    rd2_s;

    assign wr_ok_s  = wr_en && (wr_addr != {AW{1'b0}});
    assign iss_ok_s = iss_en && (iss_rd != {AW{1'b0}});
    // An issue colliding with a writeback keeps the register busy, so no decrement then.
    assign inc_s    = iss_ok_s && !busy_r[iss_rd];
    assign dec_s    = wr_ok_s && busy_r[wr_addr] && !(iss_ok_s && (iss_rd == wr_addr));

    // Returns {busy, data} for one read port.
    function automatic logic [XLEN:0] read_port(input logic [AW-1:0] a);
        logic [XLEN:0] r;
        if ((BYPASS != 0) && !rst && wr_ok_s && (a == wr_addr)) begin
            r = {1'b0, wr_data};
        end else if (a == {AW{1'b0}}) begin
            r = {(XLEN+1){1'b0}};
        end else begin
            r = {busy_r[a], regs_r[a]};
        end
        return r;
    endfunction

    // Next-state busy vector: clear on writeback, then set on issue (set wins).
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_ok_s) begin
            busy_nxt_s[wr_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (iss_ok_s) begin
            busy_nxt_s[iss_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register array, busy bits and busy counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            busy_r <= {NREGS{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                regs_r[wr_addr] <= wr_data;
            end
            busy_r <= busy_nxt_s;
            case ({inc_s, dec_s})
                2'b10:   cnt_r <= cnt_r + {{AW{1'b0}}, 1'b1};
                2'b01:   cnt_r <= cnt_r - {{AW{1'b0}}, 1'b1};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Combinational read ports.
    always_comb begin
        rd1_s = read_port(rs1_addr);
        rd2_s = read_port(rs2_addr);
    end

    assign rs1_data = rd1_s[XLEN-1:0];
    assign rs1_busy = rd1_s[XLEN];
    assign rs2_data = rd2_s[XLEN-1:0];
    assign rs2_busy = rd2_s[XLEN];
    assign busy_cnt = cnt_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed + random bench for reg_file_sb; checks a forwarding and a non-forwarding
// instance side by side against a behavioural model through an expectation queue.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0, wr_addr = 5'd0, iss_rd = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_en = 1'b0, iss_en = 1'b0;

    logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic [5:0]  b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(b_cnt)
    );

    reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(n_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] m_rd(input logic [4:0] a, input bit byp);
        if (byp && wr_en && (wr_addr != 5'd0) && (a == wr_addr)) return {1'b0, wr_data};
        if (a == 5'd0) return 33'd0;
        return {m_busy[a], m_regs[a]};
    endfunction

    function automatic logic [31:0] m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 32'(c);
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return b_rs1_data;
            1: return {31'd0, b_rs1_busy};
            2: return b_rs2_data;
            3: return {31'd0, b_rs2_busy};
            4: return {26'd0, b_cnt};
            5: return n_rs1_data;
            6: return {31'd0, n_rs1_busy};
            7: return n_rs2_data;
            8: return {31'd0, n_rs2_busy};
            9: return {26'd0, n_cnt};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Push the model's expectations for both instances, then pop and compare.
    task automatic check(input string tag);
        logic [32:0] e;
        exp_t x;
        #1;
        for (int b = 0; b < 2; b++) begin
            e = m_rd(rs1_addr, b == 0);
            sb_q.push_back('{tag, b*5 + 0, e[31:0]});
            sb_q.push_back('{tag, b*5 + 1, {31'd0, e[32]}});
            e = m_rd(rs2_addr, b == 0);
            sb_q.push_back('{tag, b*5 + 2, e[31:0]});
            sb_q.push_back('{tag, b*5 + 3, {31'd0, e[32]}});
            sb_q.push_back('{tag, b*5 + 4, m_cnt()});
        end
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            checks++;
            assert (obs(x.sel) === x.exp) else begin
                errors++;
                $error("FAIL %s sel=%0d observed=%h expected=%h", x.tag, x.sel, obs(x.sel), x.exp);
            end
        end
    endtask

    // Advance one rising edge and apply the same inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_busy = 32'd0;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hXXXX_XXXX;
        m_busy = 32'd0;
        #1;

        // Reset then read every address.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            check("reset_read");
        end

        // Write and read back; write to x0 ignored.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
        wr_en = 1'b0; rs1_addr = 5'd5; check("wr_x5");
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rs2_addr = 5'd0; check("wr_x0_cyc");
        tick(); wr_en = 1'b0; check("wr_x0");

        // Forwarding vs. non-forwarding on x7.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd7;
        check("bypass_same");
        tick(); wr_en = 1'b0; check("bypass_next");

        // Scoreboard: issue x3, x4, x3 again.
        iss_en = 1'b1; iss_rd = 5'd3; tick();
        iss_rd = 5'd4; tick();
        iss_rd = 5'd3; tick();
        iss_en = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd4; check("sb_cnt2");
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033; check("sb_wb_cyc");
        tick(); wr_en = 1'b0; check("sb_cnt1");

        // Issue/writeback collision on busy x4, then on idle x9.
        iss_en = 1'b1; iss_rd = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0044;
        check("coll_cyc");
        tick(); iss_en = 1'b0; wr_en = 1'b0; rs1_addr = 5'd4; check("coll_busy");
        iss_en = 1'b1; iss_rd = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
        tick(); iss_en = 1'b0; wr_en = 1'b0; rs2_addr = 5'd9; check("coll_idle");

        // Issue every register, re-issue one, then reset with writeback pending.
        iss_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            iss_rd = 5'(i); tick();
        end
        iss_rd = 5'd31; tick();
        iss_en = 1'b0; rs1_addr = 5'd12; rs2_addr = 5'd31; check("full_31");
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFE_F00D;
        iss_en = 1'b1; iss_rd = 5'd13; tick();
        rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0; rs2_addr = 5'd13; check("rst_mid");
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_1212; tick();
        wr_en = 1'b0; check("wb_after_rst");

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            wr_en    = 1'($urandom_range(0, 1));
            iss_en   = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            iss_rd   = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            check("rand");
            tick();
        end
        wr_en = 1'b0; iss_en = 1'b0; check("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
